// File: rtl/seq_mult16.sv
// seq_mult16: unsigned 16x16->32 shift-and-add multiplier built around a CLA16 adder
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       gg,
  output logic       pg
);
  logic [3:0] g, p;
  logic [3:0] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign s  = p ^ c;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pg = &p;
endmodule

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [3:0] gg, pg, cg;
  assign cg[0] = cin;
  assign cg[1] = gg[0] | (pg[0] & cin);
  assign cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
  assign cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & cin);
  assign cout  = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0])
               | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
  for (genvar k = 0; k < 4; k++) begin : g_grp
    cla4 u_grp (
      .a (a[4*k +: 4]),
      .b (b[4*k +: 4]),
      .ci(cg[k]),
      .s (sum[4*k +: 4]),
      .gg(gg[k]),
      .pg(pg[k])
    );
  end
endmodule

module seq_mult16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] product,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] m_q, m_d, acc_q, acc_d, q_q, q_d, sum;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] product_q, product_d;
  logic        busy_q, busy_d, done_q, done_d, cout;
  cla16 u_add (
    .a   (acc_q),
    .b   (q_q[0] ? m_q : 16'h0000),
    .cin (1'b0),
    .sum (sum),
    .cout(cout)
  );
  // next-state: iterate in RUN, otherwise accept a start (IDLE or DONE)
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (state_q == RUN) begin
      acc_d     = {cout, sum[15:1]};
      q_d       = {sum[0], q_q[15:1]};
      cnt_d     = cnt_q + 5'd1;
      state_d   = (cnt_q == 5'd15) ? DONE : RUN;
      product_d = (cnt_q == 5'd15) ? {cout, sum, q_q[15:1]} : product_q;
    end else if (start) begin
      m_d     = a;
      q_d     = b;
      acc_d   = 16'h0000;
      cnt_d   = 5'd0;
      state_d = RUN;
    end else begin
      state_d = IDLE;
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule
